// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Holds {dp, nibble} per digit and scans enabled digits with an optional blanking gap.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [7:0] digit_en,
  input  logic       blank,
  output logic [7:0] anodes,
  output logic [7:0] seg,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam int GW = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic [4:0]    regfile [8];
  logic [2:0]    first_idx;
  logic [2:0]    nxt_idx;

  function automatic logic [7:0] decode(input logic [4:0] val);
    logic [7:0] pat;
    case (val[3:0])
      4'h0: pat = 8'hFC;
      4'h1: pat = 8'h60;
      4'h2: pat = 8'hDA;
      4'h3: pat = 8'hF2;
      4'h4: pat = 8'h66;
      4'h5: pat = 8'hB6;
      4'h6: pat = 8'hBE;
      4'h7: pat = 8'hE0;
      4'h8: pat = 8'hFE;
      4'h9: pat = 8'hF6;
      4'hA: pat = 8'hEE;
      4'hB: pat = 8'h3E;
      4'hC: pat = 8'h9C;
      4'hD: pat = 8'h7A;
      4'hE: pat = 8'h9E;
      default: pat = 8'h8E;
    endcase
    decode = {pat[7:1], val[4]};
  endfunction

  function automatic logic [2:0] lowest_en(input logic [7:0] en);
    lowest_en = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (en[i]) lowest_en = 3'(i);
    end
  endfunction

  // Walk backwards so the closest enabled digit after cur is the last one assigned;
  // i = 8 wraps onto cur itself, which reselects a lone enabled digit.
  function automatic logic [2:0] next_en(input logic [2:0] cur, input logic [7:0] en);
    logic [2:0] idx;
    next_en = cur;
    for (int i = 8; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (en[idx]) next_en = idx;
    end
  endfunction

  assign first_idx = lowest_en(digit_en);
  assign nxt_idx   = next_en(digit_idx, digit_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regfile[i] <= 5'h00;
    end else if (wr_en) begin
      regfile[wr_addr] <= wr_data;
    end
  end

  // Outputs are registered from the next state; seg reads the register file as it
  // stood before this edge, giving writes a one-cycle path to the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      digit_idx  <= 3'd0;
      cnt        <= '0;
      gcnt       <= '0;
      anodes     <= 8'h00;
      seg        <= 8'h00;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (blank || digit_en == 8'h00) begin
        state  <= IDLE;
        cnt    <= '0;
        gcnt   <= '0;
        anodes <= 8'h00;
        seg    <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            state     <= SHOW;
            digit_idx <= first_idx;
            cnt       <= '0;
            anodes    <= 8'b1 << first_idx;
            seg       <= decode(regfile[first_idx]);
          end
          SHOW: begin
            if (!digit_en[digit_idx] || cnt == CNT_LAST) begin
              cnt <= '0;
              if (GAP_CYCLES == 0) begin
                digit_idx  <= nxt_idx;
                anodes     <= 8'b1 << nxt_idx;
                seg        <= decode(regfile[nxt_idx]);
                frame_tick <= (nxt_idx <= digit_idx);
              end else begin
                state  <= GAP;
                gcnt   <= '0;
                anodes <= 8'h00;
                seg    <= 8'h00;
              end
            end else begin
              cnt <= cnt + 1'b1;
              seg <= decode(regfile[digit_idx]);
            end
          end
          GAP: begin
            if (gcnt == GAP_LAST) begin
              state      <= SHOW;
              gcnt       <= '0;
              cnt        <= '0;
              digit_idx  <= nxt_idx;
              anodes     <= 8'b1 << nxt_idx;
              seg        <= decode(regfile[nxt_idx]);
              frame_tick <= (nxt_idx <= digit_idx);
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            anodes <= 8'h00;
            seg    <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule
